// File: rtl/risc_trace_pkg.sv
// Shared types for the KGP-RISC run monitor: FSM states and trace entry sizing.
package risc_trace_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } mon_state_t;

  localparam int DROP_W      = 8;
  localparam int DEF_ENTRY_W = 5 + 32 + 16;

  // A trace entry packs {addr, data, timestamp}, address in the top bits.
  function automatic int entry_width(input int addr_w, input int data_w, input int ts_w);
    return addr_w + data_w + ts_w;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO with a valid/ready drain side; a push is accepted when full if a pop
// happens in the same cycle.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic             pop;
  logic             wr_en;

  // Extra pointer bit separates full from empty when the indices coincide.
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                     (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign out_valid = !empty;
  assign pop       = !empty && out_ready;
  assign wr_en     = push && (!full || pop);
  assign out_data  = mem[rd_ptr_reg[PTR_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_reg[PTR_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/risc_trace_monitor.sv
// Run monitor for the KGP-RISC core: sequences core reset, counts run cycles, halts,
// and queues timestamped register-file changes for a debug consumer.
module risc_trace_monitor
  import risc_trace_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_REGS   = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_W       = 16,
  parameter int RST_HOLD   = 3,
  parameter int MAX_CYCLES = 0,
  parameter int ZERO_REG   = 1
) (
  input  logic                clk,
  input  logic                rst,
  output logic                core_rst,
  input  logic                rf_we,
  input  logic [ADDR_W-1:0]   rf_addr,
  input  logic [DATA_W-1:0]   rf_data,
  input  logic [NUM_REGS-1:0] watch_mask,
  input  logic                halt_in,
  output logic                trace_valid,
  input  logic                trace_ready,
  output logic [ADDR_W-1:0]   trace_addr,
  output logic [DATA_W-1:0]   trace_data,
  output logic [TS_W-1:0]     trace_ts,
  output logic [TS_W-1:0]     cycle_count,
  output logic                overflow,
  output logic [DROP_W-1:0]   drop_count,
  output logic                halted,
  output logic                done
);

  localparam int ENTRY_W = entry_width(ADDR_W, DATA_W, TS_W);
  localparam int HOLD_W  = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  mon_state_t          state_reg;
  mon_state_t          state_next;
  logic [HOLD_W-1:0]   hold_cnt_reg;
  logic [TS_W-1:0]     cycle_count_reg;
  logic                overflow_reg;
  logic [DROP_W-1:0]   drop_count_reg;
  logic [DATA_W-1:0]   shadow_reg [NUM_REGS];

  logic [NUM_REGS-1:0] sel_vec;
  logic [NUM_REGS-1:0] diff_vec;
  logic                in_run;
  logic                hold_done;
  logic                limit_hit;
  logic                zero_block;
  logic                capture;
  logic                pop;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_valid;
  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head_entry;

  assign in_run    = (state_reg == ST_RUN);
  assign hold_done = (hold_cnt_reg == HOLD_W'(RST_HOLD - 1));

  generate
    if (MAX_CYCLES == 0) begin : g_no_limit
      assign limit_hit = 1'b0;
    end else begin : g_limit
      assign limit_hit = (cycle_count_reg == TS_W'(MAX_CYCLES - 1));
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_HOLD: if (hold_done) state_next = ST_RUN;
      ST_RUN:  if (halt_in || limit_hit) state_next = ST_HALT;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_HOLD;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_reg    <= '0;
      cycle_count_reg <= '0;
    end else begin
      if (state_reg == ST_HOLD && !hold_done) hold_cnt_reg <= hold_cnt_reg + 1'b1;
      if (in_run) cycle_count_reg <= cycle_count_reg + 1'b1;
    end
  end

  // One decode slice per tracked register; out-of-range addresses match no slice.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      assign sel_vec[gi]  = rf_we && (rf_addr == ADDR_W'(gi));
      assign diff_vec[gi] = (shadow_reg[gi] != rf_data);

      always_ff @(posedge clk or posedge rst) begin
        if (rst)                      shadow_reg[gi] <= '0;
        else if (in_run && sel_vec[gi]) shadow_reg[gi] <= rf_data;
      end
    end
  endgenerate

  assign zero_block = (ZERO_REG != 0) && (rf_addr == '0);
  assign capture    = in_run && !zero_block && |(sel_vec & watch_mask & diff_vec);
  assign push_entry = {rf_addr, rf_data, cycle_count_reg};
  assign pop        = fifo_valid && trace_ready;
  assign drop       = capture && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else if (drop) begin
      overflow_reg <= 1'b1;
      if (drop_count_reg != {DROP_W{1'b1}}) drop_count_reg <= drop_count_reg + 1'b1;
    end
  end

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (push_entry),
    .out_valid (fifo_valid),
    .out_ready (trace_ready),
    .out_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign trace_valid = fifo_valid;
  assign trace_addr  = head_entry[ENTRY_W-1 -: ADDR_W];
  assign trace_data  = head_entry[TS_W +: DATA_W];
  assign trace_ts    = head_entry[TS_W-1:0];
  assign cycle_count = cycle_count_reg;
  assign overflow    = overflow_reg;
  assign drop_count  = drop_count_reg;
  assign core_rst    = (state_reg == ST_HOLD);
  assign halted      = (state_reg == ST_HALT);
  assign done        = halted && fifo_empty;

endmodule

// File: tb/tb_risc_trace_monitor.sv
// Bench for risc_trace_monitor: directed scenarios plus a random phase, checked each
// cycle against a queue-based model of the monitor's rules.
module tb_risc_trace_monitor;

  logic        clk;
  logic        rst;
  logic        core_rst;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] watch_mask;
  logic        halt_in;
  logic        trace_valid;
  logic        trace_ready;
  logic [4:0]  trace_addr;
  logic [31:0] trace_data;
  logic [15:0] trace_ts;
  logic [15:0] cycle_count;
  logic        overflow;
  logic [7:0]  drop_count;
  logic        halted;
  logic        done;

  // Second instance with a 20-cycle run limit
  logic        l_rst;
  logic        l_core_rst;
  logic        l_we;
  logic [4:0]  l_addr;
  logic [31:0] l_data;
  logic [31:0] l_mask;
  logic        l_halt_in;
  logic        l_valid;
  logic        l_ready;
  logic [4:0]  l_trace_addr;
  logic [31:0] l_trace_data;
  logic [15:0] l_trace_ts;
  logic [15:0] l_cycle_count;
  logic        l_overflow;
  logic [7:0]  l_drop_count;
  logic        l_halted;
  logic        l_done;

  risc_trace_monitor dut (
    .clk(clk), .rst(rst), .core_rst(core_rst), .rf_we(rf_we), .rf_addr(rf_addr),
    .rf_data(rf_data), .watch_mask(watch_mask), .halt_in(halt_in),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_addr(trace_addr),
    .trace_data(trace_data), .trace_ts(trace_ts), .cycle_count(cycle_count),
    .overflow(overflow), .drop_count(drop_count), .halted(halted), .done(done)
  );

  risc_trace_monitor #(.MAX_CYCLES(20)) dut_lim (
    .clk(clk), .rst(l_rst), .core_rst(l_core_rst), .rf_we(l_we), .rf_addr(l_addr),
    .rf_data(l_data), .watch_mask(l_mask), .halt_in(l_halt_in),
    .trace_valid(l_valid), .trace_ready(l_ready), .trace_addr(l_trace_addr),
    .trace_data(l_trace_data), .trace_ts(l_trace_ts), .cycle_count(l_cycle_count),
    .overflow(l_overflow), .drop_count(l_drop_count), .halted(l_halted), .done(l_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [15:0] t;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_shadow[32];
  bit          m_run;
  bit          m_halt;
  int          m_hold;
  int unsigned m_cyc;
  int          m_drops;
  bit          m_ovf;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    for (int i = 0; i < 32; i++) m_shadow[i] = '0;
    m_run   = 0;
    m_halt  = 0;
    m_hold  = 0;
    m_cyc   = 0;
    m_drops = 0;
    m_ovf   = 0;
  endtask

  // Applies the monitor's rules to the inputs present at this rising edge.
  task automatic model_edge();
    bit   pop;
    bit   cap;
    int   sz;
    ent_t e;
    if (rst) begin
      model_clear();
      return;
    end
    pop = (m_q.size() > 0) && trace_ready;
    cap = 0;
    if (m_run && rf_we) begin
      if (rf_addr != 0 && watch_mask[rf_addr] && rf_data != m_shadow[rf_addr]) cap = 1;
      m_shadow[rf_addr] = rf_data;
    end
    sz = m_q.size();
    if (pop) void'(m_q.pop_front());
    if (cap) begin
      e.a = rf_addr;
      e.d = rf_data;
      e.t = m_cyc[15:0];
      if (sz < 16 || pop) m_q.push_back(e);
      else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
    if (m_run) begin
      m_cyc = (m_cyc + 1) % 65536;
      if (halt_in) begin
        m_run  = 0;
        m_halt = 1;
      end
    end else if (!m_halt) begin
      m_hold++;
      if (m_hold == 3) m_run = 1;
    end
  endtask

  task automatic check_all();
    chk("core_rst", core_rst, !(m_run || m_halt));
    chk("cycle_count", cycle_count, m_cyc);
    chk("trace_valid", trace_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("trace_addr", trace_addr, m_q[0].a);
      chk("trace_data", trace_data, m_q[0].d);
      chk("trace_ts", trace_ts, m_q[0].t);
    end
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drops);
    chk("halted", halted, m_halt);
    chk("done", done, m_halt && m_q.size() == 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic write_at(input int ts, input logic [4:0] a, input logic [31:0] d);
    int g = 0;
    while (m_cyc != ts && g < 200) begin
      step();
      g++;
    end
    chk("write_slot", m_cyc, ts);
    rf_we   = 1'b1;
    rf_addr = a;
    rf_data = d;
    step();
    rf_we = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1; rf_we = 1'b0; rf_addr = '0; rf_data = '0; watch_mask = '0;
    halt_in = 1'b0; trace_ready = 1'b0;
    l_rst = 1'b1; l_we = 1'b0; l_addr = '0; l_data = '0; l_mask = '0;
    l_halt_in = 1'b0; l_ready = 1'b0;
    model_clear();

    // Reset state, then core_rst release after exactly three edges
    #1;
    check_all();
    chk("rst_core_rst", core_rst, 1'b1);
    #9 rst = 1'b0;
    step();
    chk("t1_hold_e1", core_rst, 1'b1);
    step();
    chk("t1_hold_e2", core_rst, 1'b1);
    step();
    chk("t1_run_core_rst", core_rst, 1'b0);
    chk("t1_first_cyc", cycle_count, 16'd0);

    // Change filter: repeated value is not traced
    watch_mask = '1;
    write_at(4, 5'd1, 32'd5);
    write_at(6, 5'd1, 32'd5);
    write_at(9, 5'd1, 32'd7);
    chk("t2_e0_addr", trace_addr, 5'd1);
    chk("t2_e0_data", trace_data, 32'd5);
    chk("t2_e0_ts", trace_ts, 16'd4);
    trace_ready = 1'b1;
    step();
    chk("t2_e1_addr", trace_addr, 5'd1);
    chk("t2_e1_data", trace_data, 32'd7);
    chk("t2_e1_ts", trace_ts, 16'd9);
    step();
    chk("t2_empty", trace_valid, 1'b0);
    trace_ready = 1'b0;

    // Seventeen distinct writes into a 16-deep FIFO with no consumer
    for (int i = 0; i < 17; i++) begin
      rf_we = 1'b1; rf_addr = 5'd2; rf_data = 32'h100 + i;
      step();
    end
    rf_we = 1'b0;
    chk("t3_overflow", overflow, 1'b1);
    chk("t3_drops", drop_count, 8'd1);
    chk("t3_head", trace_data, 32'h100);

    // Push and pop together while full
    rf_we = 1'b1; rf_addr = 5'd2; rf_data = 32'h999; trace_ready = 1'b1;
    step();
    rf_we = 1'b0; trace_ready = 1'b0;
    chk("t4_drops", drop_count, 8'd1);
    chk("t4_head", trace_data, 32'h101);
    step();
    chk("t4_drops_hold", drop_count, 8'd1);

    trace_ready = 1'b1;
    repeat (20) step();

    // Random traffic: small data alphabet forces shadow hits, bursty ready forces drops
    for (int i = 0; i < 400; i++) begin
      rf_we       = 1'($urandom_range(0, 1));
      rf_addr     = 5'($urandom_range(0, 31));
      rf_data     = 32'($urandom_range(0, 3));
      watch_mask  = $urandom;
      trace_ready = (i % 100 < 50) ? 1'($urandom_range(0, 1)) : (($urandom_range(0, 7)) == 0);
      step();
    end
    rf_we = 1'b0;
    trace_ready = 1'b1;
    repeat (20) step();
    trace_ready = 1'b0;

    // Reset mid-run with five entries queued
    watch_mask = '1;
    for (int i = 0; i < 5; i++) begin
      rf_we = 1'b1; rf_addr = 5'd4; rf_data = 32'h40 + i;
      step();
    end
    rf_we = 1'b0;
    chk("t6_queued", trace_valid, 1'b1);
    #3 rst = 1'b1;
    model_clear();
    #1;
    chk("t6_valid", trace_valid, 1'b0);
    chk("t6_overflow", overflow, 1'b0);
    chk("t6_core_rst", core_rst, 1'b1);
    chk("t6_cyc", cycle_count, 16'd0);
    step();
    #2 rst = 1'b0;
    repeat (3) step();
    chk("t6_rerun", core_rst, 1'b0);

    // halt_in coincident with a qualifying write; later writes ignored
    repeat (5) step();
    rf_we = 1'b1; rf_addr = 5'd5; rf_data = 32'h55; halt_in = 1'b1;
    step();
    halt_in = 1'b0;
    chk("t7_halted", halted, 1'b1);
    chk("t7_cap_data", trace_data, 32'h55);
    chk("t7_cap_ts", trace_ts, 16'd5);
    chk("t7_cyc", cycle_count, 16'd6);
    rf_addr = 5'd6; rf_data = 32'h66;
    repeat (3) step();
    rf_we = 1'b0;
    chk("t7_frozen", cycle_count, 16'd6);
    trace_ready = 1'b1;
    step();
    chk("t7_done", done, 1'b1);
    trace_ready = 1'b0;

    // Cycle limit on the second instance
    l_mask = '1; l_we = 1'b1; l_addr = 5'd3; l_data = 32'd1;
    l_rst = 1'b0;
    k = 0;
    while (k < 60) begin
      step();
      k++;
      l_data = l_data + 1;
      if (l_halted) break;
    end
    chk("t5_halt_edge", k, 23);
    chk("t5_halted", l_halted, 1'b1);
    chk("t5_cyc", l_cycle_count, 16'd20);
    chk("t5_drops", l_drop_count, 8'd4);
    chk("t5_first_ts", l_trace_ts, 16'd0);
    chk("t5_not_done", l_done, 1'b0);
    l_ready = 1'b1;
    repeat (15) step();
    chk("t5_draining", l_done, 1'b0);
    step();
    chk("t5_done", l_done, 1'b1);
    chk("t5_cyc_frozen", l_cycle_count, 16'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
